blur_sram_arbiter: RTL
======================

BLUR_SRAM_ARBITER -- requirements
Module: blur_sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9: SRAM row address width.
REQ-002 Parameter DATA_W, default 5120: SRAM row width in bits.
REQ-003 Parameter ROWS, default 481: rows per frame, addresses 0..ROWS-1.
REQ-004 Parameter STARVE_MAX, default 8: maximum consecutive denials of an eligible read.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 frame_start  in  1  one-cycle pulse that opens a new frame.
REQ-009 wr_req  in  1  write request; held by the writer until granted.
REQ-010 wr_addr  in  ADDR_W  write row address.
REQ-011 wr_data  in  DATA_W  write row data.
REQ-012 wr_gnt  out  1  write granted this cycle.
REQ-013 rd_req  in  1  read request; held by the reader until granted.
REQ-014 rd_addr  in  ADDR_W  read row address.
REQ-015 rd_gnt  out  1  read granted this cycle.
REQ-016 rd_valid  out  1  rd_data valid; asserted one cycle after rd_gnt.
REQ-017 rd_data  out  DATA_W  read row data.
REQ-018 sram_we  out  1  single-port SRAM write enable.
REQ-019 sram_addr  out  ADDR_W  SRAM address.
REQ-020 sram_din  out  DATA_W  SRAM write data.
REQ-021 sram_dout  in  DATA_W  SRAM read data; valid the cycle after a read address is applied.
REQ-022 watermark  out  ADDR_W+1  count of rows written in order in the current frame.
REQ-023 busy  out  1  high while the block is in the FILL state.
REQ-024 frame_done  out  1  one-cycle pulse when watermark reaches ROWS.

Function
REQ-025 The block SHALL grant at most one SRAM access per cycle, with wr_gnt and rd_gnt never high together.
REQ-026 Grants SHALL be combinational from the current requests and state.
REQ-027 On wr_gnt: sram_we=1, sram_addr=wr_addr, sram_din=wr_data.
REQ-028 On rd_gnt: sram_we=0 and sram_addr=rd_addr.
REQ-029 With no grant: sram_we=0, sram_addr=0, sram_din=0.
REQ-030 The FSM SHALL have three states: IDLE, FILL and FULL.
REQ-031 IDLE SHALL go to FILL on frame_start.
REQ-032 FILL SHALL go to FULL in the cycle watermark becomes ROWS.
REQ-033 FULL SHALL go to FILL on frame_start.
REQ-034 In FILL, frame_start SHALL restart the frame and the state SHALL remain FILL.
REQ-035 Writes SHALL be granted only in FILL; in IDLE and FULL, wr_req SHALL be ignored and wr_gnt held at 0.
REQ-036 A read is eligible when rd_req=1, the state is FILL or FULL, and rd_addr < watermark.
REQ-037 Ineligible reads SHALL never be granted.
REQ-038 Priority: the writer wins, unless starve_cnt == STARVE_MAX and the read is eligible, in which case the reader wins.
REQ-039 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle an eligible read is denied.
REQ-040 starve_cnt SHALL clear on rd_gnt or frame_start.
REQ-041 On a granted write with wr_addr == watermark, watermark SHALL increment by 1; any other granted write SHALL leave watermark unchanged.
REQ-042 watermark SHALL saturate at ROWS.
REQ-043 frame_start SHALL clear watermark and starve_cnt, and SHALL deny both requesters in that cycle.
REQ-044 A rd_valid already due from the previous cycle SHALL still be delivered in a frame_start cycle.
REQ-045 rd_valid SHALL be registered from rd_gnt.
REQ-046 rd_data SHALL equal sram_dout while rd_valid=1, and 0 otherwise.
REQ-047 frame_done SHALL be registered, pulsing high in the cycle after watermark reaches ROWS.

Reset
REQ-048 While rst_n=0: state=IDLE, watermark=0, starve_cnt=0, rd_valid=0, frame_done=0, busy=0, and all grants and SRAM controls are 0.
REQ-049 Reset asserted mid-frame SHALL abort immediately; any pending rd_valid SHALL be dropped.

Verification
REQ-050 frame_start, then 481 back-to-back in-order writes with addresses 0..480 -> watermark=481, one frame_done pulse, state=FULL, busy=0.
REQ-051 Reader continuously requests addr 5 while the writer is at watermark 3 -> rd_gnt=0 until the write of row 5 is granted; rd_gnt is asserted in the following cycle.
REQ-052 Writer and eligible reader both request continuously -> every 9th cycle is rd_gnt, with STARVE_MAX=8 writes between reads; rd_valid follows each rd_gnt by 1 cycle with rd_data=sram_dout.
REQ-053 frame_start in the same cycle as wr_req and a pending rd_valid -> wr_gnt=0, rd_valid=1 is delivered, watermark=0.
REQ-054 Write to addr 7 while watermark=3 -> sram_we=1 and watermark stays 3; in state FULL, wr_req -> wr_gnt=0.
REQ-055 rst_n pulled low mid-frame with watermark=200 -> all outputs 0 immediately; after release, reads are denied until the next frame_start.

Source files
------------

// File: rtl/blur_sram_arbiter.sv
// rtl/blur_sram_arbiter.sv - single-port SRAM arbiter between a row writer and a row reader
//
// Arbitrates one single-port SRAM between an in-order row writer and a
// reader that may only fetch rows already written in the current frame.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   frame_start            one-cycle pulse opening a new frame
//   wr_req/wr_addr/wr_data write request (held until wr_gnt)
//   wr_gnt                 write granted this cycle
//   rd_req/rd_addr         read request (held until rd_gnt)
//   rd_gnt                 read granted this cycle
//   rd_valid/rd_data       read data, one cycle after rd_gnt
//   sram_we/sram_addr/sram_din/sram_dout  SRAM port
//   watermark              rows written in order this frame
//   busy                   high while filling
//   frame_done             one-cycle pulse when the frame is complete
module blur_sram_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 5120,
   parameter int ROWS       = 481,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic [ADDR_W:0]   watermark,
   output logic              busy,
   output logic              frame_done
);

   localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W:0] ROWS_W     = (ADDR_W + 1)'(ROWS);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t          state;
   logic [SC_W-1:0] starve_cnt;
   logic            wr_cand;
   logic            rd_elig;
   logic            wm_inc;
   logic            wm_hit;

   // frame_start blanks both requesters so the new frame starts from a clean
   // watermark; the reader only wins once it has been starved STARVE_MAX times.
   always_comb begin
      wr_cand = wr_req && (state == FILL) && !frame_start;
      rd_elig = rd_req && (state != IDLE) && ({1'b0, rd_addr} < watermark) && !frame_start;
      rd_gnt  = rd_elig && (!wr_cand || (starve_cnt == STARVE_LIM));
      wr_gnt  = wr_cand && !rd_gnt;
      // Only an in-order write advances the watermark; rewrites and
      // out-of-order writes land in the SRAM but are not counted.
      wm_inc  = wr_gnt && ({1'b0, wr_addr} == watermark) && (watermark != ROWS_W);
      wm_hit  = wm_inc && ((watermark + (ADDR_W + 1)'(1)) == ROWS_W);
   end

   always_comb begin
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      if (wr_gnt) begin
         sram_we   = 1'b1;
         sram_addr = wr_addr;
         sram_din  = wr_data;
      end else if (rd_gnt) begin
         sram_addr = rd_addr;
      end
   end

   assign rd_data = rd_valid ? sram_dout : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         watermark  <= '0;
         starve_cnt <= '0;
         rd_valid   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         // A read granted last cycle is delivered even across frame_start.
         rd_valid   <= rd_gnt;
         frame_done <= wm_hit;
         if (frame_start) begin
            state      <= FILL;
            busy       <= 1'b1;
            watermark  <= '0;
            starve_cnt <= '0;
         end else begin
            if (wm_inc) begin
               watermark <= watermark + (ADDR_W + 1)'(1);
            end
            if (wm_hit) begin
               state <= FULL;
               busy  <= 1'b0;
            end
            if (rd_gnt) begin
               starve_cnt <= '0;
            end else if (rd_elig && (starve_cnt != STARVE_LIM)) begin
               starve_cnt <= starve_cnt + SC_W'(1);
            end
         end
      end
   end

endmodule
